spi_master_shifter: RTL and testbench

Data path of the SPI master, directly downstream of the SCK/CS generator. Consumes its one-cycle `sck_first_edge` / `sck_second_edge` strobes and `spi_finish`, serialises a parallel TX word onto `mosi` and deserialises `miso` into a parallel RX word, honouring CPHA and bit order. Presents the received word with a one-cycle `rx_valid` pulse to the register/host side.

---
 rtl/spi_master_shifter_pkg.sv | 16 +
 rtl/spi_master_shifter_if.sv | 26 ++
 rtl/spi_master_shifter.sv | 139 +++++++++++++
 tb/tb_spi_master_shifter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_shifter_pkg.sv
// Shared SPI definitions: FSM encodings, default frame-size log and clock-mode names.
// Used by both the SCK/CS generator and the data-path shifter.
package spi_master_shifter_pkg;

  localparam int SPI_MAX_WIDTH_LOG_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic CPHA_FIRST_EDGE  = 1'b0;
  localparam logic CPHA_SECOND_EDGE = 1'b1;
  localparam logic CPOL_IDLE_LOW    = 1'b0;
  localparam logic CPOL_IDLE_HIGH   = 1'b1;

endpackage

// File: rtl/spi_master_shifter_if.sv
// Host-side bundle of the shifter: frame request/config in, received word out.
// spi_start is a single-cycle request; rx_valid is a single-cycle, unacknowledged result pulse.
interface spi_master_shifter_if #(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int DATA_WIDTH        = 2**SPI_MAX_WIDTH_LOG
);
  logic                         spi_start;
  logic                         cpha;
  logic                         msb_first;
  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width;
  logic [DATA_WIDTH-1:0]        tx_data;
  logic [DATA_WIDTH-1:0]        rx_data;
  logic                         rx_valid;
  logic                         rx_err;
  logic                         busy;

  modport master (
    output spi_start, cpha, msb_first, spi_width, tx_data,
    input  rx_data, rx_valid, rx_err, busy
  );

  modport slave (
    input  spi_start, cpha, msb_first, spi_width, tx_data,
    output rx_data, rx_valid, rx_err, busy
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master data path: serialises tx_data onto mosi and assembles miso into rx_data,
// driven by the generator's one-cycle edge strobes, honouring CPHA and bit order.
module spi_master_shifter
  import spi_master_shifter_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = SPI_MAX_WIDTH_LOG_DEFAULT,
  parameter int DATA_WIDTH        = 2**SPI_MAX_WIDTH_LOG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_shifter_if.slave   host,
  input  logic                  sck_first_edge,
  input  logic                  sck_second_edge,
  input  logic                  spi_finish,
  input  logic                  miso,
  output logic                  mosi,
  output logic [1:0]            dbg_state
);

  localparam int LW = SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [LW-1:0] IDX_ONE = LW'(1);
  localparam logic [LW-1:0] IDX_ZERO = '0;

  // Position of the k-th serial bit within a word of W+1 bits.
  function automatic logic [LW-1:0] bit_pos(input logic [LW-1:0] k,
                                            input logic [LW-1:0] w,
                                            input logic          msb);
    return msb ? (w - k) : k;
  endfunction

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [LW-1:0]         w_q;
  logic                  cpha_q;
  logic                  msb_q;
  logic [DATA_WIDTH-1:0] rx_sh_q;
  logic [CW-1:0]         cnt_q;
  logic [LW-1:0]         drv_idx_q;
  logic                  first_seen_q;
  logic                  mosi_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_err_q;

  logic                  sample_stb;
  logic                  drive_stb;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [CW-1:0]         cnt_next;
  logic [CW-1:0]         cnt_eff;
  logic [CW-1:0]         frame_bits;
  logic                  frame_full;
  logic                  done_now;

  // Sample has priority: a drive strobe coinciding with a sample strobe is dropped.
  assign sample_stb = cpha_q ? sck_second_edge : sck_first_edge;
  assign drive_stb  = (cpha_q ? sck_first_edge : sck_second_edge) && !sample_stb;

  always_comb begin
    rx_next = rx_sh_q;
    rx_next[bit_pos(cnt_q[LW-1:0], w_q, msb_q)] = miso;
  end

  assign cnt_next   = cnt_q + CNT_ONE;
  assign cnt_eff    = sample_stb ? cnt_next : cnt_q;
  assign frame_bits = {1'b0, w_q} + CNT_ONE;
  assign frame_full = (cnt_eff == frame_bits);
  assign done_now   = frame_full || spi_finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tx_q         <= '0;
      w_q          <= '0;
      cpha_q       <= 1'b0;
      msb_q        <= 1'b0;
      rx_sh_q      <= '0;
      cnt_q        <= '0;
      drv_idx_q    <= '0;
      first_seen_q <= 1'b0;
      mosi_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (host.spi_start) begin
            tx_q         <= host.tx_data;
            w_q          <= host.spi_width;
            cpha_q       <= host.cpha;
            msb_q        <= host.msb_first;
            rx_sh_q      <= '0;
            cnt_q        <= '0;
            drv_idx_q    <= '0;
            first_seen_q <= 1'b0;
            mosi_q       <= host.tx_data[bit_pos(IDX_ZERO, host.spi_width, host.msb_first)];
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sample_stb) begin
            rx_sh_q <= rx_next;
            cnt_q   <= cnt_next;
          end else if (drive_stb) begin
            // With CPHA=1 the opening first edge only launches the preloaded bit.
            if (cpha_q && !first_seen_q) begin
              first_seen_q <= 1'b1;
            end else if (drv_idx_q != w_q) begin
              drv_idx_q <= drv_idx_q + IDX_ONE;
              mosi_q    <= tx_q[bit_pos(drv_idx_q + IDX_ONE, w_q, msb_q)];
            end
          end
          if (done_now) begin
            state_q    <= ST_DONE;
            rx_valid_q <= 1'b1;
            rx_data_q  <= sample_stb ? rx_next : rx_sh_q;
            rx_err_q   <= !frame_full;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          mosi_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mosi          = mosi_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
  assign host.rx_err   = rx_err_q;
  assign host.busy     = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: plays the SCK/CS generator, checks mosi and the received
// word against a bit-list reference model of the frame.
`timescale 1ns/1ps
module tb_spi_master_shifter;

  logic       clk;
  logic       rst_n;
  logic       sck_first_edge;
  logic       sck_second_edge;
  logic       spi_finish;
  logic       miso;
  logic       mosi;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  spi_master_shifter_if #(.SPI_MAX_WIDTH_LOG(4)) hif ();

  spi_master_shifter #(.SPI_MAX_WIDTH_LOG(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host            (hif),
    .sck_first_edge  (sck_first_edge),
    .sck_second_edge (sck_second_edge),
    .spi_finish      (spi_finish),
    .miso            (miso),
    .mosi            (mosi),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bit k of the frame (k=0 first on the wire) lives at word index W-k (MSB first) or k.
  function automatic int wire_pos(input int k, input int w, input bit msb);
    return msb ? (w - k) : k;
  endfunction

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic pulse_first();
    sck_first_edge = 1'b1;
    @(negedge clk);
    sck_first_edge = 1'b0;
  endtask

  task automatic pulse_second();
    sck_second_edge = 1'b1;
    @(negedge clk);
    sck_second_edge = 1'b0;
  endtask

  // ---------------- driver: one complete frame ----------------
  // fin_after < w+1 ends the frame through spi_finish after that many samples.
  task automatic run_frame(input logic [15:0] tx, input int w, input bit msb, input bit cph,
                           input logic [15:0] stream, input bit loopback, input int fin_after,
                           input bit mid_start);
    int          nsamp;
    logic [15:0] exp_rx;
    logic        tb_bit;
    logic        rx_bit;
    logic [15:0] exp_tx_bits[$];
    nsamp  = (fin_after < w + 1) ? fin_after : w + 1;
    exp_rx = '0;
    for (int k = 0; k <= w; k++) exp_tx_bits.push_back(tx[wire_pos(k, w, msb)]);

    @(negedge clk);
    hif.spi_start = 1'b1;
    hif.tx_data   = tx;
    hif.spi_width = 4'(w);
    hif.cpha      = cph;
    hif.msb_first = msb;
    @(negedge clk);
    hif.spi_start = 1'b0;
    hif.tx_data   = 16'($urandom);
    hif.spi_width = 4'($urandom);
    hif.cpha      = 1'($urandom);
    hif.msb_first = 1'($urandom);
    check_eq("busy_rise", 32'(hif.busy), 32'd1);
    check_eq("mosi_first", 32'(mosi), 32'(exp_tx_bits[0]));

    for (int k = 0; k < nsamp; k++) begin
      if (cph) begin
        pulse_first();
        gap();
      end
      tb_bit = exp_tx_bits[k][0];
      rx_bit = loopback ? tb_bit : stream[wire_pos(k, w, msb)];
      check_eq($sformatf("mosi_bit%0d", k), 32'(mosi), 32'(tb_bit));
      miso = rx_bit;
      exp_rx[wire_pos(k, w, msb)] = rx_bit;
      if (cph) sck_second_edge = 1'b1;
      else     sck_first_edge  = 1'b1;
      if (mid_start && k == 1) begin
        hif.spi_start = 1'b1;
        hif.tx_data   = ~tx;
      end
      @(negedge clk);
      sck_first_edge  = 1'b0;
      sck_second_edge = 1'b0;
      hif.spi_start   = 1'b0;
      miso            = 1'($urandom);
      if (k < nsamp - 1 || nsamp < w + 1)
        check_eq("rx_valid_early", 32'(hif.rx_valid), 32'd0);
      if (k < nsamp - 1) begin
        if (!cph) begin
          gap();
          pulse_second();
        end
        gap();
      end
    end

    if (nsamp < w + 1) begin
      gap();
      spi_finish = 1'b1;
      @(negedge clk);
      spi_finish = 1'b0;
    end

    check_eq("rx_valid", 32'(hif.rx_valid), 32'd1);
    check_eq("rx_data", 32'(hif.rx_data), 32'(exp_rx));
    check_eq("rx_err", 32'(hif.rx_err), (nsamp < w + 1) ? 32'd1 : 32'd0);
    check_eq("busy_done", 32'(hif.busy), 32'd1);
    @(negedge clk);
    check_eq("rx_valid_fall", 32'(hif.rx_valid), 32'd0);
    check_eq("busy_fall", 32'(hif.busy), 32'd0);
    check_eq("mosi_idle", 32'(mosi), 32'd0);
    check_eq("rx_data_hold", 32'(hif.rx_data), 32'(exp_rx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mosi"}, 32'(mosi), 32'd0);
    check_eq({tag, "_rx_data"}, 32'(hif.rx_data), 32'd0);
    check_eq({tag, "_rx_valid"}, 32'(hif.rx_valid), 32'd0);
    check_eq({tag, "_rx_err"}, 32'(hif.rx_err), 32'd0);
    check_eq({tag, "_busy"}, 32'(hif.busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    sck_first_edge  = 1'b0;
    sck_second_edge = 1'b0;
    spi_finish      = 1'b0;
    miso            = 1'b0;
    hif.spi_start   = 1'b0;
    hif.cpha        = 1'b0;
    hif.msb_first   = 1'b0;
    hif.spi_width   = '0;
    hif.tx_data     = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames
    run_frame(16'h00A5, 7, 1'b1, 1'b0, 16'h0000, 1'b1, 99, 1'b0);
    run_frame(16'h0001, 7, 1'b0, 1'b1, 16'hFFFF, 1'b0, 99, 1'b0);
    run_frame(16'h8001, 15, 1'b1, 1'b0, 16'h1234, 1'b0, 99, 1'b0);
    run_frame(16'h005A, 7, 1'b1, 1'b0, 16'h00FF, 1'b0, 3, 1'b0);
    run_frame(16'h005A, 7, 1'b0, 1'b1, 16'h00FF, 1'b0, 3, 1'b0);
    run_frame(16'h00C3, 7, 1'b1, 1'b0, 16'h003C, 1'b0, 99, 1'b1);
    run_frame(16'h0001, 0, 1'b1, 1'b1, 16'h0001, 1'b0, 99, 1'b0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      int w;
      int fin;
      w   = $urandom_range(0, 15);
      fin = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : 99;
      run_frame(16'($urandom), w, 1'($urandom), 1'($urandom), 16'($urandom),
                1'($urandom), fin, 1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    hif.spi_start = 1'b1;
    hif.tx_data   = 16'h00FF;
    hif.spi_width = 4'd7;
    hif.cpha      = 1'b0;
    hif.msb_first = 1'b1;
    @(negedge clk);
    hif.spi_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      miso = 1'b1;
      pulse_first();
      pulse_second();
    end
    check_eq("pre_reset_busy", 32'(hif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    for (int k = 0; k < 3; k++) begin
      sck_first_edge = 1'($urandom);
      @(negedge clk);
      check_eq("reset_no_valid", 32'(hif.rx_valid), 32'd0);
    end
    sck_first_edge = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
    run_frame(16'h3C96, 11, 1'b0, 1'b0, 16'h0ABC, 1'b0, 99, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
